// File: rtl/tms_status_uart_tx_if.sv
// rtl/tms_status_uart_tx_if.sv - stage/error strobes in, GPIO status and UART line out
interface tms_status_uart_tx_if;
    logic       stage_wr;
    logic [7:0] stage_in;
    logic       err_set;
    logic [7:0] test_stage;
    logic       error_flag;
    logic       uart_tx;
    logic       busy;
    logic       overflow;

    // Sequencer side: issues strobes, observes status.
    modport master (
        output stage_wr,
        output stage_in,
        output err_set,
        input  test_stage,
        input  error_flag,
        input  uart_tx,
        input  busy,
        input  overflow
    );

    // Reporter side.
    modport slave (
        input  stage_wr,
        input  stage_in,
        input  err_set,
        output test_stage,
        output error_flag,
        output uart_tx,
        output busy,
        output overflow
    );
endinterface

// File: rtl/tms_status_uart_tx.sv
// rtl/tms_status_uart_tx.sv - self-test stage/error latch with 8N1 UART stage reporter
module tms_status_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    tms_status_uart_tx_if.slave   bus
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        uart_tx_r;
    logic        busy_r;

    logic [7:0]  test_stage_r;
    logic        error_flag_r;
    logic        overflow_r;

    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_ptr_nxt;
    logic [AW:0] rd_ptr_nxt;

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic drop;
    logic nonempty_nxt;

    // Full when the pointers address the same slot but sit on different laps.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a write to a full queue is
    // only dropped when the transmitter is not taking a byte.
    assign pop  = (state == IDLE) && !fifo_empty;
    assign push = bus.stage_wr && (!fifo_full || pop);
    assign drop = bus.stage_wr && fifo_full && !pop;

    assign wr_ptr_nxt   = push ? (wr_ptr + PTR_ONE) : wr_ptr;
    assign rd_ptr_nxt   = pop  ? (rd_ptr + PTR_ONE) : rd_ptr;
    assign nonempty_nxt = (wr_ptr_nxt != rd_ptr_nxt);

    // Byte storage; contents are don't-care until written, so no reset.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= bus.stage_in;
        end
    end

    // Queue pointers and the GPIO-facing status registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            test_stage_r <= 8'h00;
            error_flag_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            if (bus.stage_wr) begin
                test_stage_r <= bus.stage_in;
            end
            if (bus.err_set) begin
                error_flag_r <= 1'b1;
            end
            if (drop) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Transmit FSM: the line level and busy are computed for the state being
    // entered, so both outputs come straight from flops.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            baud_cnt  <= 16'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            uart_tx_r <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    uart_tx_r <= 1'b1;
                    if (pop) begin
                        shift_reg <= fifo_mem[rd_ptr[AW-1:0]];
                        baud_cnt  <= 16'd0;
                        state     <= START;
                        uart_tx_r <= 1'b0;
                        busy_r    <= 1'b1;
                    end else begin
                        busy_r <= nonempty_nxt;
                    end
                end
                START: begin
                    busy_r <= 1'b1;
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt  <= 16'd0;
                        bit_idx   <= 3'd0;
                        state     <= DATA;
                        uart_tx_r <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    busy_r <= 1'b1;
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt  <= 16'd0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state     <= STOP;
                            uart_tx_r <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            uart_tx_r <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    uart_tx_r <= 1'b1;
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= 16'd0;
                        state    <= IDLE;
                        busy_r   <= nonempty_nxt;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                        busy_r   <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    uart_tx_r <= 1'b1;
                    busy_r    <= nonempty_nxt;
                end
            endcase
        end
    end

    assign bus.test_stage = test_stage_r;
    assign bus.error_flag = error_flag_r;
    assign bus.overflow   = overflow_r;
    assign bus.uart_tx    = uart_tx_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_tms_status_uart_tx.sv
// tb/tb_tms_status_uart_tx.sv - scoreboard bench for the stage/error UART reporter
module tb_tms_status_uart_tx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;

    tms_status_uart_tx_if bus();

    tms_status_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .bus     (bus)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: bytes waiting in the queue, cycles until the line is
    // free again, and the latched status values.
    logic [7:0] q_model[$];
    logic [7:0] sb[$];
    int         line_busy  = 0;
    logic [7:0] exp_stage  = 8'h00;
    logic       exp_err    = 1'b0;
    logic       exp_ovf    = 1'b0;
    int         cyc        = 0;

    initial forever begin
        @(posedge wb_clk_i or posedge wb_rst_i);
        if (wb_rst_i) begin
            q_model.delete();
            sb.delete();
            line_busy = 0;
            exp_stage = 8'h00;
            exp_err   = 1'b0;
            exp_ovf   = 1'b0;
        end else begin
            if (line_busy == 0 && q_model.size() > 0) begin
                void'(q_model.pop_front());
                line_busy = FRAME;
            end else if (line_busy > 0) begin
                line_busy--;
            end
            if (bus.stage_wr) begin
                exp_stage = bus.stage_in;
                if (q_model.size() < DEPTH) begin
                    q_model.push_back(bus.stage_in);
                    sb.push_back(bus.stage_in);
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            if (bus.err_set) begin
                exp_err = 1'b1;
            end
        end
    end

    // Status monitor: every falling edge compares the registered outputs.
    initial forever begin
        @(negedge wb_clk_i);
        cyc++;
        check("test_stage", bus.test_stage, exp_stage);
        check("error_flag", bus.error_flag, exp_err);
        check("overflow",   bus.overflow,   exp_ovf);
        check("busy",       bus.busy,       (line_busy > 0 || q_model.size() > 0));
    end

    // UART receiver: checks every cycle of each frame against the byte at
    // the head of the scoreboard, and decodes mid-bit samples.
    logic [7:0] got[$];
    int         starts[$];
    bit         rx_active = 1'b0;
    int         rx_cnt    = 0;
    logic [9:0] rx_pat    = 10'h3FF;
    logic [7:0] rx_byte   = 8'h00;
    bit         rx_ok     = 1'b1;
    logic       prev_line = 1'b1;

    initial forever begin
        @(negedge wb_clk_i);
        if (wb_rst_i) begin
            rx_active = 1'b0;
            prev_line = 1'b1;
        end else if (!rx_active) begin
            if (bus.uart_tx === 1'b0 && prev_line === 1'b1) begin
                rx_active = 1'b1;
                rx_cnt    = 1;
                rx_ok     = 1'b1;
                starts.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                    rx_pat = 10'h3FF;
                end else begin
                    rx_pat = {1'b1, sb[0], 1'b0};
                end
            end else begin
                check("idle_line", bus.uart_tx, 1);
            end
            prev_line = bus.uart_tx;
        end else begin
            if (bus.uart_tx !== rx_pat[rx_cnt / CPB]) rx_ok = 1'b0;
            if ((rx_cnt % CPB) == CPB / 2 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8)
                rx_byte[rx_cnt / CPB - 1] = bus.uart_tx;
            if (rx_cnt == FRAME - 1) begin
                check("frame_shape", rx_ok, 1);
                check("frame_byte", rx_byte, rx_pat[8:1]);
                got.push_back(rx_byte);
                if (sb.size() > 0) void'(sb.pop_front());
                rx_active = 1'b0;
            end
            rx_cnt++;
            prev_line = bus.uart_tx;
        end
    end

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < budget) begin
            @(negedge wb_clk_i);
            #1;
            n++;
            if (!bus.busy && !rx_active) done = 1'b1;
        end
        check(name, done, 1);
    endtask

    task automatic write_one(input logic [7:0] v);
        @(negedge wb_clk_i);
        bus.stage_wr = 1'b1;
        bus.stage_in = v;
        @(negedge wb_clk_i);
        bus.stage_wr = 1'b0;
    endtask

    logic [7:0] t3_vals [4] = '{8'h00, 8'h01, 8'h02, 8'hFE};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.stage_wr = 1'b0;
        bus.stage_in = 8'h00;
        bus.err_set  = 1'b0;
        wb_rst_i     = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        check("rst_stage", bus.test_stage, 8'h00);
        check("rst_err",   bus.error_flag, 0);
        check("rst_ovf",   bus.overflow,   0);
        check("rst_tx",    bus.uart_tx,    1);
        check("rst_busy",  bus.busy,       0);
        @(posedge wb_clk_i);
        #2 wb_rst_i = 1'b0;

        // Quiet line after reset.
        repeat (1000) @(negedge wb_clk_i);
        check("t1_no_frames", got.size(), 0);

        // Single 0xFF frame with exact first-edge timing.
        got.delete();
        @(negedge wb_clk_i);
        bus.stage_wr = 1'b1;
        bus.stage_in = 8'hFF;
        @(posedge wb_clk_i);
        #1;
        check("t2_stage_next", bus.test_stage, 8'hFF);
        check("t2_busy_next",  bus.busy, 1);
        check("t2_tx_still_hi", bus.uart_tx, 1);
        @(negedge wb_clk_i);
        bus.stage_wr = 1'b0;
        @(posedge wb_clk_i);
        #1;
        check("t2_tx_start", bus.uart_tx, 0);
        wait_idle("t2_idle", 400);
        check("t2_count", got.size(), 1);
        if (got.size() >= 1) check("t2_byte", got[0], 8'hFF);

        // Four back-to-back writes.
        got.delete();
        starts.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk_i);
            bus.stage_wr = 1'b1;
            bus.stage_in = t3_vals[i];
        end
        @(negedge wb_clk_i);
        bus.stage_wr = 1'b0;
        wait_idle("t3_idle", 2000);
        check("t3_stage", bus.test_stage, 8'hFE);
        check("t3_ovf", bus.overflow, 0);
        check("t3_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) check("t3_byte", got[i], t3_vals[i]);
        for (int i = 1; i < starts.size(); i++) check("t3_spacing", starts[i] - starts[i-1], FRAME + 1);

        // Six writes into a four-deep queue: one dropped.
        got.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge wb_clk_i);
            bus.stage_wr = 1'b1;
            bus.stage_in = 8'h10 + 8'(i);
        end
        @(negedge wb_clk_i);
        bus.stage_wr = 1'b0;
        #1;
        check("t4_ovf", bus.overflow, 1);
        check("t4_stage", bus.test_stage, 8'h15);
        wait_idle("t4_idle", 2000);
        check("t4_count", got.size(), 5);
        for (int i = 0; i < got.size() && i < 5; i++) check("t4_byte", got[i], 8'h10 + i);

        // Error strobe in the middle of a frame.
        got.delete();
        write_one(8'h03);
        repeat (40) @(negedge wb_clk_i);
        bus.err_set = 1'b1;
        @(negedge wb_clk_i);
        bus.err_set = 1'b0;
        #1;
        check("t5_err_set", bus.error_flag, 1);
        wait_idle("t5_idle", 400);
        check("t5_count", got.size(), 1);
        if (got.size() >= 1) check("t5_byte", got[0], 8'h03);
        repeat (20) @(negedge wb_clk_i);
        check("t5_err_sticky", bus.error_flag, 1);

        // Reset in the data bits of 0xA5, then a clean 0x5A.
        got.delete();
        write_one(8'hA5);
        repeat (40) @(negedge wb_clk_i);
        @(posedge wb_clk_i);
        #2 wb_rst_i = 1'b1;
        #1;
        check("t6_tx_hi",  bus.uart_tx, 1);
        check("t6_busy",   bus.busy, 0);
        check("t6_err",    bus.error_flag, 0);
        check("t6_ovf",    bus.overflow, 0);
        @(negedge wb_clk_i);
        @(posedge wb_clk_i);
        #2 wb_rst_i = 1'b0;
        repeat (200) @(negedge wb_clk_i);
        check("t6_no_partial", got.size(), 0);
        check("t6_busy_after", bus.busy, 0);
        write_one(8'h5A);
        wait_idle("t6_idle", 400);
        check("t6_count", got.size(), 1);
        if (got.size() >= 1) check("t6_byte", got[0], 8'h5A);

        // Randomised traffic: dense bursts then sparse writes.
        for (int i = 0; i < 4000; i++) begin
            @(negedge wb_clk_i);
            if (i < 1000) bus.stage_wr = ($urandom_range(7) == 0);
            else          bus.stage_wr = ($urandom_range(149) == 0);
            bus.stage_in = 8'($urandom);
            bus.err_set  = ($urandom_range(299) == 0);
        end
        @(negedge wb_clk_i);
        bus.stage_wr = 1'b0;
        bus.err_set  = 1'b0;
        wait_idle("rand_idle", 2000);
        check("rand_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tms_status_uart_tx.md
# tms_status_uart_tx

Status reporter inside the TMS1x00 user project: latches the current self-test stage code and a sticky error flag, and drives them on the GPIO bank the bench monitors (stage bits and error bit). It also queues every stage code written and serialises it as 8N1 UART on the UART TX pad. It is the transmitting end of the bench-side UART receiver and stage monitor. The CPU or test sequencer writes stage and error strobes; this block reports them off-chip.

## Interface
- CLKS_PER_BIT, 16: clock cycles per UART bit; legal range 4..65535.
- FIFO_DEPTH, 4: byte queue depth; must be a power of two, 2..16.

- wb_clk_i  input  1  single system clock; all state on its rising edge.
- wb_rst_i  input  1  asynchronous, active-high reset.
- stage_wr  input  1  one-cycle strobe; writes stage_in.
- stage_in  input  8  stage code (0xFF = started, 0xFE = pass).
- err_set  input  1  one-cycle strobe; sets the sticky error flag.
- test_stage  output  8  registered last stage code; drives GPIO[15:8].
- error_flag  output  1  sticky error; drives GPIO[31].
- uart_tx  output  1  serial line; idle high; drives GPIO[6].
- busy  output  1  high while a frame is in flight or the FIFO is non-empty.
- overflow  output  1  sticky; set when a stage_wr is dropped.

## Operation
- Reset (asynchronous, immediate):
  - test_stage=0x00, error_flag=0, overflow=0, uart_tx=1, busy=0.
  - FIFO emptied; FSM forced to IDLE; bit counter and baud counter cleared.
  - Reset during a frame aborts it; no partial bits follow.
- stage_wr:
  - test_stage <= stage_in.
  - Byte is pushed into the FIFO.
  - A write of the same value as the current test_stage is still queued.
- FIFO full with stage_wr:
  - test_stage still updates; the byte is dropped; overflow <= 1.
  - Exception: if the FSM pops in the same cycle, the push is accepted and no overflow occurs.
- err_set: error_flag <= 1. Only reset clears it; nothing is transmitted.
- Simultaneous stage_wr and err_set: both take effect.
- Transmit FSM, 8N1, LSB first:
  - IDLE: uart_tx=1. If FIFO non-empty: pop into the shift register, clear the baud counter, go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: uart_tx=shift[0] for CLKS_PER_BIT cycles; shift right; after bit index 7 go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - From IDLE, a queued byte starts on the next cycle, so the inter-frame idle is exactly 1 cycle.
- Baud counter: 16-bit, counts 0..CLKS_PER_BIT-1 and wraps. Bit index: 3-bit.
- FIFO: read/write pointers of log2(FIFO_DEPTH)+1 bits. Wrap-around is handled by pointer MSB compare.
- busy = (state != IDLE) | FIFO non-empty.
- All outputs are registered; uart_tx must be glitch-free.

## Timing
- stage_wr sampled at edge N:
  - test_stage valid after edge N; busy high after edge N.
  - FSM pops at edge N+1; uart_tx low after edge N+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles, from the uart_tx falling edge to the end of the stop bit.
- Back-to-back queued bytes: the next start bit begins 10*CLKS_PER_BIT+1 cycles after the previous start bit.
- err_set at edge N: error_flag high after edge N.
- Overflow at edge N: overflow high after edge N.
- busy falls at the edge that returns the FSM to IDLE, provided the FIFO is empty.

## Test plan
- Reset release, no strobes for 1000 cycles -> uart_tx=1, test_stage=0x00, error_flag=0, busy=0 throughout.
- stage_wr 0xFF, CLKS_PER_BIT=16:
  - test_stage=0xFF one cycle later.
  - Line low for 16 cycles, then bits 1,1,1,1,1,1,1,1, then stop high.
  - Bench UART decodes 0xFF; frame is 160 cycles.
- Writes 0x00, 0x01, 0x02, 0xFE on consecutive cycles -> test_stage=0xFE; four frames decoded in order 00,01,02,FE; start-to-start spacing 161 cycles; overflow=0.
- Six writes 0x10..0x15 on consecutive cycles, FIFO_DEPTH=4:
  - First pop at write 2 frees one slot, so 0x10..0x14 are sent.
  - 0x15 is dropped; overflow=1; test_stage=0x15.
- err_set mid-frame while transmitting 0x03 -> error_flag=1 next cycle; frame 0x03 completes intact; error_flag stays 1 until reset.
- wb_rst_i pulsed during the DATA state of frame 0xA5:
  - uart_tx=1 in the same cycle; busy=0; FIFO empty.
  - A later stage_wr 0x5A transmits a clean 0x5A frame.
